// File: rtl/branch_resolver.sv
// branch_resolver
// Consumer end of the comparison_unit flag interface, at the EX/branch boundary.
// It accepts one branch op per handshake and decides taken or not-taken from the
// condition code and the eq/lt/gt flags. A taken branch produces a one-cycle PC
// redirect to pc+offset, and then the front-end flush is held for FLUSH_CYCLES cycles.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        op handshake (in_ready low while flushing)
//   cond, equal, less_than,
//   greater_than, pc, offset   branch op payload, sampled only on the accept edge
//   pc_load, pc_target         redirect strobe and address (address held between strobes)
//   flush                      flush younger stages
//   flag_error, err_clr        sticky non-one-hot flag indicator and its synchronous clear
//   taken_cnt                  saturating count of taken branches
module branch_resolver #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cond,
  input  logic             equal,
  input  logic             less_than,
  input  logic             greater_than,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_target,
  output logic             flush,
  output logic             flag_error,
  input  logic             err_clr,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [FC_W-1:0] fcnt;
  logic            accept, cond_op, bad_flags, raw_taken, taken;

  assign in_ready  = (state == IDLE);
  assign flush     = (state == FLUSH);
  assign accept    = in_valid & in_ready;
  // Only the compare-based ops look at the flags; NONE and JMP never flag an error.
  assign cond_op   = (cond != 3'b000) && (cond != 3'b111);
  assign bad_flags = cond_op && !$onehot({equal, less_than, greater_than});
  assign taken     = accept & raw_taken & ~bad_flags;

  always_comb begin
    raw_taken = 1'b0;
    case (cond)
      3'b001:  raw_taken = equal;
      3'b010:  raw_taken = ~equal;
      3'b011:  raw_taken = less_than;
      3'b100:  raw_taken = greater_than;
      3'b101:  raw_taken = greater_than | equal;
      3'b110:  raw_taken = less_than | equal;
      3'b111:  raw_taken = 1'b1;
      default: raw_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (taken) state_nxt = FLUSH;
      FLUSH:   if (fcnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Loaded on the accept edge, so the first FLUSH cycle already sees FLUSH_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         fcnt <= '0;
    else if (taken)                     fcnt <= FC_W'(FLUSH_CYCLES - 1);
    else if (flush && fcnt != '0)       fcnt <= fcnt - FC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_load   <= 1'b0;
      pc_target <= '0;
      taken_cnt <= '0;
    end else begin
      pc_load <= taken;
      if (taken) begin
        pc_target <= pc + offset;
        if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

  // If a new error arrives in the same cycle as err_clr, the new error is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  flag_error <= 1'b0;
    else if (accept & bad_flags) flag_error <= 1'b1;
    else if (err_clr)            flag_error <= 1'b0;
  end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, err_clr;
  logic [2:0]  cond;
  logic        equal, less_than, greater_than;
  logic [31:0] pc, offset;

  logic        in_ready, pc_load, flush, flag_error;
  logic [31:0] pc_target;
  logic [15:0] taken_cnt;

  logic        s_in_ready, s_pc_load, s_flush, s_flag_error;
  logic [31:0] s_pc_target;
  logic [1:0]  s_taken_cnt;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .equal(equal), .less_than(less_than), .greater_than(greater_than),
    .pc(pc), .offset(offset), .pc_load(pc_load), .pc_target(pc_target),
    .flush(flush), .flag_error(flag_error), .err_clr(err_clr), .taken_cnt(taken_cnt)
  );

  // Narrow counter instance to exercise saturation; shares all stimulus.
  branch_resolver #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .cond(cond), .equal(equal), .less_than(less_than), .greater_than(greater_than),
    .pc(pc), .offset(offset), .pc_load(s_pc_load), .pc_target(s_pc_target),
    .flush(s_flush), .flag_error(s_flag_error), .err_clr(err_clr), .taken_cnt(s_taken_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_redirect(input logic [31:0] tgt, input logic [31:0] cnt);
    exp_t e;
    e.tgt = tgt;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Present one op; returns at accept edge + 1.
  task automatic send(input logic [2:0] c, input logic e, input logic l, input logic g,
                      input logic [31:0] p, input logic [31:0] o);
    cond = c; equal = e; less_than = l; greater_than = g; pc = p; offset = o;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every redirect strobe must match the oldest expected redirect.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && pc_load === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pc_load: got pc_target %0h expected no strobe", pc_target);
      end else begin
        e = sb.pop_front();
        chk("pc_target", pc_target, e.tgt);
        chk("taken_cnt_at_load", {16'h0, taken_cnt}, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sat_exp [5];
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0; cond = 3'b000;
    equal = 1'b0; less_than = 1'b0; greater_than = 1'b0; pc = '0; offset = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flag_error", flag_error, 0);
    chk("rst_taken_cnt", taken_cnt, 0);

    // 1) BEQ taken
    expect_redirect(32'h120, 1);
    send(3'b001, 1, 0, 0, 32'h100, 32'h20);
    chk("t1_flush_c1", flush, 1);
    chk("t1_ready_c1", in_ready, 0);
    step();
    chk("t1_flush_c2", flush, 1);
    chk("t1_ready_c2", in_ready, 0);
    step();
    chk("t1_flush_end", flush, 0);
    chk("t1_ready_end", in_ready, 1);
    chk("t1_taken_cnt", taken_cnt, 1);

    // 2) BLT not taken, then BGE taken back-to-back (offset -16)
    send(3'b011, 0, 0, 1, 32'h300, 32'h40);
    chk("t2_ready_nt", in_ready, 1);
    chk("t2_flush_nt", flush, 0);
    expect_redirect(32'h1F0, 2);
    send(3'b101, 0, 0, 1, 32'h200, 32'hFFFF_FFF0);
    chk("t2_flush_bge", flush, 1);
    step(); step();
    chk("t2_ready_end", in_ready, 1);

    // 3) bad flags -> error, not taken; set beats err_clr
    send(3'b010, 1, 1, 0, 32'h400, 32'h8);
    chk("t3_flag_error", flag_error, 1);
    chk("t3_not_taken", flush, 0);
    err_clr = 1'b1;
    send(3'b110, 1, 0, 1, 32'h400, 32'h8);
    err_clr = 1'b0;
    chk("t3_set_wins", flag_error, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_err_clr", flag_error, 0);
    send(3'b000, 1, 1, 1, 32'h400, 32'h8);
    chk("t3_none_no_err", flag_error, 0);
    chk("t3_none_ready", in_ready, 1);
    chk("t3_taken_cnt", taken_cnt, 2);

    // 4) JMP with wrap; op offered during flush is ignored
    expect_redirect(32'h10, 3);
    send(3'b111, 0, 0, 0, 32'hFFFF_FFF0, 32'h20);
    chk("t4_no_err", flag_error, 0);
    cond = 3'b111; pc = 32'h500; offset = 32'h4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t4_flush_c2", flush, 1);
    chk("t4_ready_c2", in_ready, 0);
    step();
    chk("t4_ready_end", in_ready, 1);
    step();
    chk("t4_cnt_after_ignore", taken_cnt, 3);

    // 5) reset during second flush cycle
    expect_redirect(32'h4, 4);
    send(3'b111, 0, 0, 0, 32'h0, 32'h4);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_flush_rst", flush, 0);
    chk("t5_ready_rst", in_ready, 1);
    chk("t5_cnt_rst", taken_cnt, 0);
    chk("t5_target_rst", pc_target, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // 6) saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      expect_redirect(32'h1000 + 32'(i) * 32'h10 + 32'h8, 32'(i + 1));
      send(3'b111, 0, 0, 0, 32'h1000 + 32'(i) * 32'h10, 32'h8);
      chk($sformatf("t6_sat_cnt%0d", i), {30'h0, s_taken_cnt}, sat_exp[i]);
      step(); step();
    end

    step();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
